// File: rtl/alu_exec.sv
// Multi-cycle integer execute unit: single-cycle add/sub/logic, bit-serial shifts,
// valid/ready handshake on both sides with a registered result.
module alu_exec #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      alu_ctl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};
    localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

    state_t            state_r, state_s;
    logic [2:0]        op_r;
    logic [SHW-1:0]    cnt_r;
    logic [XLEN-1:0]   shift_r, shift_next_s;
    logic [XLEN-1:0]   result_r;
    logic              illegal_r, out_valid_r;
    logic              accept_s, go_shift_s, is_shift_s;
    logic [SHW-1:0]    shamt_s;

    // Shifts with a zero amount degenerate to a pass-through of op_a.
    function automatic logic [XLEN-1:0] calc_single(input logic [2:0]      ctl,
                                                     input logic [XLEN-1:0] a,
                                                     input logic [XLEN-1:0] b);
        case (ctl)
            OP_ADD:                 calc_single = a + b;
            OP_SUB:                 calc_single = a - b;
            OP_AND:                 calc_single = a & b;
            OP_OR:                  calc_single = a | b;
            OP_SLL, OP_SRL, OP_SRA: calc_single = a;
            default:                calc_single = {XLEN{1'b0}};
        endcase
    endfunction

    assign shamt_s    = op_b[SHW-1:0];
    assign is_shift_s = (alu_ctl == OP_SLL) || (alu_ctl == OP_SRL) || (alu_ctl == OP_SRA);
    assign go_shift_s = is_shift_s && (shamt_s != CNT_ZERO);
    assign accept_s   = in_valid && in_ready;

    // Input-side ready: depends only on state and out_ready.
    always_comb begin
        in_ready = 1'b0;
        if (state_r == ST_IDLE) begin
            in_ready = 1'b1;
        end else if (state_r == ST_DONE) begin
            in_ready = out_ready;
        end else begin
            in_ready = 1'b0;
        end
    end

    // One-bit step of the working register; SRA replicates the captured sign bit.
    always_comb begin
        shift_next_s = shift_r;
        case (op_r)
            OP_SLL:  shift_next_s = {shift_r[XLEN-2:0], 1'b0};
            OP_SRL:  shift_next_s = {1'b0, shift_r[XLEN-1:1]};
            OP_SRA:  shift_next_s = {shift_r[XLEN-1], shift_r[XLEN-1:1]};
            default: shift_next_s = shift_r;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; DONE with a handshake follows any request accepted alongside it.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = go_shift_s ? ST_SHIFT : ST_DONE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == CNT_ONE) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (accept_s) begin
                    state_s = go_shift_s ? ST_SHIFT : ST_DONE;
                end else if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Datapath: capture at accept, iterate in SHIFT, hold result until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r        <= 3'b000;
            cnt_r       <= CNT_ZERO;
            shift_r     <= {XLEN{1'b0}};
            result_r    <= {XLEN{1'b0}};
            illegal_r   <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            op_r      <= alu_ctl;
            cnt_r     <= shamt_s;
            shift_r   <= op_a;
            illegal_r <= (alu_ctl == OP_ILL);
            if (go_shift_s) begin
                out_valid_r <= 1'b0;
            end else begin
                result_r    <= calc_single(alu_ctl, op_a, op_b);
                out_valid_r <= 1'b1;
            end
        end else if (state_r == ST_SHIFT) begin
            shift_r <= shift_next_s;
            cnt_r   <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
                result_r    <= shift_next_s;
                out_valid_r <= 1'b1;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign illegal   = illegal_r;

endmodule

// File: tb/tb_alu_exec.sv
// Directed and randomized self-checking bench for alu_exec.
module tb_alu_exec;

    localparam logic [2:0] C_ADD = 3'b000;
    localparam logic [2:0] C_SUB = 3'b001;
    localparam logic [2:0] C_SLL = 3'b010;
    localparam logic [2:0] C_SRL = 3'b011;
    localparam logic [2:0] C_SRA = 3'b100;
    localparam logic [2:0] C_AND = 3'b101;
    localparam logic [2:0] C_OR  = 3'b110;
    localparam logic [2:0] C_ILL = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_ctl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    alu_exec #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctl   (alu_ctl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            C_ADD:   ref_alu = a + b;
            C_SUB:   ref_alu = a - b;
            C_SLL:   ref_alu = a << b[4:0];
            C_SRL:   ref_alu = a >> b[4:0];
            C_SRA:   ref_alu = $signed(a) >>> b[4:0];
            C_AND:   ref_alu = a & b;
            C_OR:    ref_alu = a | b;
            default: ref_alu = 32'h0;
        endcase
    endfunction

    // Present a request and return 1ns after the accepting edge; inputs are then scrambled.
    task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        int k;
        @(posedge clk); #1;
        in_valid = 1'b1; alu_ctl = c; op_a = a; op_b = b;
        k = 0;
        while (!in_ready && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        chk("accept_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; alu_ctl = ~c; op_a = ~a; op_b = ~b;
    endtask

    // Count negedges until out_valid is seen (bounded).
    task automatic wait_out(output int cyc);
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (out_valid) break;
        end
    endtask

    initial begin
        int cyc;
        logic [2:0]  rc;
        logic [31:0] ra, rb, rexp;
        int rlat, stall;

        rst_n = 1'b0; in_valid = 1'b0; alu_ctl = 3'b000; op_a = 32'h0; op_b = 32'h0; out_ready = 1'b1;
        #7;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk); rst_n = 1'b1;

        issue(C_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
        wait_out(cyc);
        chk("add_lat", cyc, 32'd1);
        chk("add_res", result, 32'h0000_0000);
        chk("add_ill", {31'd0, illegal}, 32'd0);

        issue(C_SUB, 32'h0, 32'h1);
        wait_out(cyc);
        chk("sub_lat", cyc, 32'd1);
        chk("sub_res", result, 32'hFFFF_FFFF);

        issue(C_SRA, 32'h8000_0000, 32'd31);
        wait_out(cyc);
        chk("sra_lat", cyc, 32'd32);
        chk("sra_res", result, 32'hFFFF_FFFF);

        issue(C_SRL, 32'h8000_0000, 32'd31);
        wait_out(cyc);
        chk("srl_lat", cyc, 32'd32);
        chk("srl_res", result, 32'h0000_0001);

        issue(C_SLL, 32'h1, 32'h0000_0020);
        wait_out(cyc);
        chk("sll0_lat", cyc, 32'd1);
        chk("sll0_res", result, 32'h0000_0001);

        issue(C_ILL, 32'h1234_5678, 32'h0000_0003);
        wait_out(cyc);
        chk("ill_res", result, 32'h0);
        chk("ill_flag", {31'd0, illegal}, 32'd1);

        issue(C_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
        wait_out(cyc);
        chk("and_res", result, 32'hF000_F000);
        chk("and_ill", {31'd0, illegal}, 32'd0);

        // Asynchronous reset in the middle of a long shift
        issue(C_SLL, 32'h1, 32'd20);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_result", result, 32'h0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("postrst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (25) @(negedge clk);
        chk("postrst_dropped", {31'd0, out_valid}, 32'd0);

        // Backpressure with a pending request
        out_ready = 1'b0;
        issue(C_OR, 32'h0000_000F, 32'h0000_00F0);
        in_valid = 1'b1; alu_ctl = C_ADD; op_a = 32'd2; op_b = 32'd3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_result", result, 32'h0000_00FF);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_next_res", result, 32'd5);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_drain", {31'd0, out_valid}, 32'd0);

        // Back-to-back stream of ADDs
        @(posedge clk); #1;
        in_valid = 1'b1; alu_ctl = C_ADD; op_a = 32'd0; op_b = 32'd100;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i < 7) op_a = 32'(i + 1);
            else in_valid = 1'b0;
            @(negedge clk);
            chk("b2b_valid", {31'd0, out_valid}, 32'd1);
            chk("b2b_res", result, 32'(i + 100));
        end
        @(posedge clk); #1;

        // Random mix against a reference model with random stalls
        for (int n = 0; n < 40; n++) begin
            rc = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            rexp = ref_alu(rc, ra, rb);
            rlat = ((rc == C_SLL || rc == C_SRL || rc == C_SRA) && rb[4:0] != 5'd0) ? int'(rb[4:0]) + 1 : 1;
            issue(rc, ra, rb);
            out_ready = 1'b0;
            wait_out(cyc);
            chk("rnd_lat", cyc, 32'(rlat));
            chk("rnd_res", result, rexp);
            chk("rnd_ill", {31'd0, illegal}, {31'd0, rc == C_ILL});
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                chk("rnd_hold", result, rexp);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
